apb_master_sequencer: RTL and testbench

Back-end sequencer of the AXI-to-APB bridge. Accepts single or burst transactions from the AXI protocol handler's internal interface, pulls write data from the write FIFO, and runs APB3 SETUP/ACCESS phases toward two peripheral windows. It returns per-beat read data and status, or a single write completion with status.

---
 rtl/apb_master_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_apb_master_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_sequencer.sv
// apb_master_sequencer
// Back-end sequencer of the AXI-to-APB bridge. Takes single or burst
// transactions from the protocol handler, pulls write data from the write
// FIFO (first-word-fall-through), and runs APB3 SETUP/ACCESS phases toward
// two 4 KB peripheral windows (0x0001_Fxxx -> psel_o[0], 0x0002_Fxxx ->
// psel_o[1]).
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   wr_trans_i, rd_trans_i        start strobes (read wins), sampled in IDLE only
//   trans_addr_i, burst_len_i     start address, beats minus one
//   fifo_rdata_i, fifo_empty_i    write FIFO head / empty flag
//   fifo_rden_o                   pop write FIFO
//   read_data_o                   read beat data
//   trans_done_o, trans_error_o   done pulse (per read beat, once per write) and status
//   psel_o, penable_o, pwrite_o   APB controls
//   paddr_o, pwdata_o             APB address / write data
//   prdata0_i, prdata1_i          slave read data
//   pready_i, pslverr_i           per-slave ready / error, indexed like psel_o
//
// Build option
//   APB_TIMEOUT_EN : when defined, an ACCESS phase that sees no pready for
//                    TIMEOUT_CYCLES cycles ends the beat with an error.
//
// state  | meaning
// IDLE   | waiting for a start strobe
// WFETCH | write only: waiting for a FIFO word, pops it into pwdata
// SETUP  | APB setup phase (or decode-error beat end)
// ACCESS | APB access phase, waiting for pready of the selected slave
module apb_master_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_trans_i,
  input  logic                  rd_trans_i,
  input  logic [ADDR_WIDTH-1:0] trans_addr_i,
  input  logic [3:0]            burst_len_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  trans_done_o,
  output logic                  trans_error_o,
  output logic [1:0]            psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata0_i,
  input  logic [DATA_WIDTH-1:0] prdata1_i,
  input  logic [1:0]            pready_i,
  input  logic [1:0]            pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WFETCH = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-13:0] WIN0 = (ADDR_WIDTH-12)'(20'h0001F);
  localparam logic [ADDR_WIDTH-13:0] WIN1 = (ADDR_WIDTH-12)'(20'h0002F);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  derr_q, derr_d;

  logic                  hit0, hit1, dec_ok, sel_idx;
  logic [1:0]            sel_onehot;
  logic                  pready_sel, pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  last_beat;
  logic                  beat_end, beat_err;
  logic [DATA_WIDTH-1:0] beat_rdata;

  // The burst never leaves its 4 KB window, so decode is constant per burst.
  assign hit0        = (addr_q[ADDR_WIDTH-1:12] == WIN0);
  assign hit1        = (addr_q[ADDR_WIDTH-1:12] == WIN1);
  assign dec_ok      = hit0 | hit1;
  assign sel_idx     = hit1;
  assign sel_onehot  = {hit1, hit0};
  assign pready_sel  = pready_i[sel_idx];
  assign pslverr_sel = pslverr_i[sel_idx];
  assign prdata_sel  = sel_idx ? prdata1_i : prdata0_i;
  assign addr_next   = {addr_q[ADDR_WIDTH-1:12], addr_q[11:0] + 12'd4};
  assign last_beat   = (cnt_q == len_q);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expired;
  // Loaded in SETUP, reaches zero in the TIMEOUT_CYCLES-th ACCESS cycle.
  assign tmo_expired = (tmo_q == '0);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    sticky_d    = sticky_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    derr_d      = 1'b0;
    beat_end    = 1'b0;
    beat_err    = 1'b0;
    beat_rdata  = '0;
    fifo_rden_o = 1'b0;
    psel_o      = 2'b00;
    penable_o   = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (rd_trans_i || wr_trans_i) begin
          addr_d   = trans_addr_i;
          len_d    = burst_len_i;
          cnt_d    = 4'd0;
          sticky_d = 1'b0;
          write_d  = !rd_trans_i;
          state_d  = rd_trans_i ? SETUP : WFETCH;
        end
      end

      WFETCH: begin
        if (!fifo_empty_i) begin
          fifo_rden_o = 1'b1;
          wdata_d     = fifo_rdata_i;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        if (dec_ok) begin
          psel_o  = sel_onehot;
          state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          beat_end = 1'b1;
          beat_err = 1'b1;
        end
      end

      ACCESS: begin
        psel_o    = sel_onehot;
        penable_o = 1'b1;
        if (pready_sel) begin
          beat_end   = 1'b1;
          beat_err   = pslverr_sel;
          beat_rdata = prdata_sel;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_expired) begin
          beat_end = 1'b1;
          beat_err = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    if (beat_end) begin
      addr_d = addr_next;
      if (!write_q) begin
        rdata_d = beat_rdata;
        done_d  = 1'b1;
        derr_d  = beat_err;
      end else begin
        sticky_d = sticky_q | beat_err;
        if (last_beat) begin
          done_d = 1'b1;
          derr_d = sticky_q | beat_err;
        end
      end
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        state_d = write_q ? WFETCH : SETUP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      sticky_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      derr_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      sticky_q <= sticky_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      derr_q   <= derr_d;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign paddr_o       = addr_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign read_data_o   = rdata_q;
  assign trans_done_o  = done_q;
  assign trans_error_o = derr_q;

endmodule

// File: tb/tb_apb_master_sequencer.sv
module tb_apb_master_sequencer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_trans_i = 1'b0, rd_trans_i = 1'b0;
  logic [AW-1:0] trans_addr_i = '0;
  logic [3:0]    burst_len_i = '0;
  logic [DW-1:0] fifo_rdata_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_rden_o;
  logic [DW-1:0] read_data_o;
  logic          trans_done_o, trans_error_o;
  logic [1:0]    psel_o;
  logic          penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata0_i = '0, prdata1_i = '0;
  logic [1:0]    pready_i = '0, pslverr_i = '0;

  always #5 clk = ~clk;

  apb_master_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_trans_i(wr_trans_i), .rd_trans_i(rd_trans_i),
    .trans_addr_i(trans_addr_i), .burst_len_i(burst_len_i),
    .fifo_rdata_i(fifo_rdata_i), .fifo_empty_i(fifo_empty_i), .fifo_rden_o(fifo_rden_o),
    .read_data_o(read_data_o), .trans_done_o(trans_done_o), .trans_error_o(trans_error_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata0_i(prdata0_i), .prdata1_i(prdata1_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  typedef struct { logic [31:0] addr; bit wr; logic [31:0] wdata; logic [1:0] psel; } acc_t;
  typedef struct { logic [31:0] data; bit err; bit chk_data; } done_t;
  typedef struct { int waits; bit err; logic [31:0] data; } plan_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  plan_t       plan_q[$];
  logic [31:0] fifo_q[$];

  int n_checks = 0, n_errors = 0;
  int acc_seen = 0, acc_exp = 0, done_seen = 0, done_exp = 0;
  int pop_cnt = 0, exp_pops = 0;
  bit pop_pending = 0, stall = 0;
  bit in_acc = 0;
  int wcnt = 0;
  plan_t cur;

  int          bw[16];
  bit          be[16];
  logic [31:0] bd[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_update();
    fifo_empty_i = stall || (fifo_q.size() == 0);
    fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  // Sampled mid-cycle: completed APB accesses and done pulses against the model.
  task automatic monitor_step();
    acc_t  ea;
    done_t ed;
    if (psel_o != 2'b00 && penable_o && pready_i[psel_o[1]]) begin
      acc_seen++;
      if (exp_acc.size() != 0) begin
        ea = exp_acc.pop_front();
        chk("acc_paddr", paddr_o, ea.addr);
        chk("acc_psel", psel_o, ea.psel);
        chk("acc_pwrite", pwrite_o, ea.wr);
        if (ea.wr) chk("acc_pwdata", pwdata_o, ea.wdata);
      end
    end
    if (trans_done_o) begin
      done_seen++;
      if (exp_done.size() != 0) begin
        ed = exp_done.pop_front();
        chk("done_error", trans_error_o, ed.err);
        if (ed.chk_data) chk("done_rdata", read_data_o, ed.data);
      end
    end
    pop_pending = fifo_rden_o;
  endtask

  // APB slave pair: the selected slave answers from the plan queue; the other
  // one toggles its ready/error/data randomly, which the DUT must ignore.
  task automatic slave_step();
    logic [1:0] rdy, err;
    bit s;
    if (!rst_n) begin
      in_acc = 0; pready_i = '0; pslverr_i = '0;
      return;
    end
    rdy = 2'($urandom());
    err = 2'($urandom());
    prdata0_i = $urandom();
    prdata1_i = $urandom();
    if (psel_o != 2'b00 && penable_o) begin
      s = psel_o[1];
      if (!in_acc) begin
        if (plan_q.size() != 0) cur = plan_q.pop_front();
        else begin cur.waits = 0; cur.err = 0; cur.data = '0; end
        in_acc = 1;
        wcnt = cur.waits;
      end
      rdy[s] = (wcnt == 0);
      err[s] = cur.err && (wcnt == 0);
      if (s) prdata1_i = cur.data; else prdata0_i = cur.data;
      if (wcnt != 0) wcnt--;
    end else begin
      in_acc = 0;
    end
    pready_i  = rdy;
    pslverr_i = err;
  endtask

  task automatic fifo_step();
    if (!rst_n) pop_pending = 0;
    if (pop_pending) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_cnt++;
      pop_pending = 0;
    end
    fifo_update();
  endtask

  // One clock cycle: monitor at the falling edge, bench drive 1 ns after rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor_step(); else pop_pending = 0;
    @(posedge clk);
    #1;
    slave_step();
    fifo_step();
  endtask

  task automatic fill_beats(input int max_wait, input int err_pct);
    for (int i = 0; i < 16; i++) begin
      bw[i] = $urandom_range(0, max_wait);
      be[i] = ($urandom_range(0, 99) < err_pct);
      bd[i] = $urandom();
    end
  endtask

  // Transaction-level reference: beat addresses wrap inside the 4 KB page,
  // window decode by page number, reads report per beat, writes once with OR of errors.
  task automatic launch(input bit wr, input bit rd, input logic [31:0] a, input int len);
    bit          is_rd, any_err, berr, timed;
    int          lo, sel;
    logic [31:0] ba, word, bdata;
    acc_t        ea;
    done_t       ed;
    plan_t       p;
    is_rd   = rd;
    any_err = 0;
    if (a[31:12] == 20'h0001F)      sel = 0;
    else if (a[31:12] == 20'h0002F) sel = 1;
    else                            sel = -1;
    for (int i = 0; i <= len; i++) begin
      lo    = (int'(a[11:0]) + 4 * i) % 4096;
      ba    = {a[31:12], 12'(lo)};
      word  = $urandom();
      berr  = 1;
      bdata = '0;
      timed = 0;
      if (!is_rd) fifo_q.push_back(word);
      if (sel >= 0) begin
`ifdef APB_TIMEOUT_EN
        timed = (bw[i] >= TMO);
`endif
        p.waits = bw[i]; p.err = be[i]; p.data = bd[i];
        plan_q.push_back(p);
        if (!timed) begin
          ea.addr = ba; ea.wr = !is_rd; ea.wdata = word;
          ea.psel = (sel == 1) ? 2'b10 : 2'b01;
          exp_acc.push_back(ea);
          acc_exp++;
          berr  = be[i];
          bdata = bd[i];
        end
      end
      if (is_rd) begin
        ed.data = bdata; ed.err = berr; ed.chk_data = (sel >= 0);
        exp_done.push_back(ed);
        done_exp++;
      end else begin
        any_err = any_err | berr;
      end
    end
    if (!is_rd) begin
      ed.data = '0; ed.err = any_err; ed.chk_data = 0;
      exp_done.push_back(ed);
      done_exp++;
      exp_pops += len + 1;
    end
    wr_trans_i   = wr;
    rd_trans_i   = rd;
    trans_addr_i = a;
    burst_len_i  = 4'(len);
    fifo_update();
    tick();
    wr_trans_i   = 0;
    rd_trans_i   = 0;
    trans_addr_i = $urandom();
    burst_len_i  = 4'($urandom());
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_done.size() != 0 || exp_acc.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_in_budget"}, c < budget, 1);
    tick();
    tick();
    chk({tag, "_done_count"}, done_seen, done_exp);
    chk({tag, "_access_count"}, acc_seen, acc_exp);
    chk({tag, "_fifo_pops"}, pop_cnt, exp_pops);
  endtask

  initial begin
    int          c, len;
    bit          wr, rd;
    logic [31:0] a;

    // Reset state
    tick(); tick();
    chk("rst_psel", psel_o, 2'b00);
    chk("rst_penable", penable_o, 0);
    chk("rst_done", trans_done_o, 0);
    chk("rst_rden", fifo_rden_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_rdata", read_data_o, 0);
    rst_n = 1;
    tick();

    // Single read, zero wait: cycle-exact latency
    fill_beats(0, 0);
    bd[0] = 32'hCAFE_0001;
    launch(0, 1, 32'h0001_F000, 0);
    chk("lat_setup_psel", psel_o, 2'b01);
    chk("lat_setup_penable", penable_o, 0);
    tick();
    chk("lat_access_psel", psel_o, 2'b01);
    chk("lat_access_penable", penable_o, 1);
    tick();
    chk("lat_done", trans_done_o, 1);
    chk("lat_rdata", read_data_o, 32'hCAFE_0001);
    chk("lat_err", trans_error_o, 0);
    chk("lat_psel_drop", psel_o, 2'b00);
    tick();
    chk("lat_done_pulse", trans_done_o, 0);
    wait_done("single_read", 50);

    // Burst read with page wrap, back-to-back beats every 2 cycles
    fill_beats(0, 0);
    launch(0, 1, 32'h0002_FFF8, 3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("burst_done_spacing", trans_done_o, (k % 2) == 0);
      chk("burst_psel", psel_o, (k < 8) ? 2'b10 : 2'b00);
    end
    wait_done("burst_read", 50);

    // Write burst with an initially empty FIFO, error on beat 1 only
    stall = 1;
    fill_beats(0, 0);
    be[1] = 1;
    launch(1, 0, 32'h0002_F100, 2);
    for (int k = 0; k < 5; k++) begin
      chk("stall_psel", psel_o, 2'b00);
      chk("stall_rden", fifo_rden_o, 0);
      tick();
    end
    stall = 0;
    fifo_update();
    wait_done("stalled_write", 100);

    // Decode error
    fill_beats(0, 0);
    launch(0, 1, 32'h0003_0000, 0);
    chk("decerr_psel_setup", psel_o, 2'b00);
    tick();
    chk("decerr_done", trans_done_o, 1);
    chk("decerr_error", trans_error_o, 1);
    chk("decerr_psel", psel_o, 2'b00);
    wait_done("decode_error", 20);

    // Simultaneous start: read wins, write ignored (no FIFO pop)
    fill_beats(1, 30);
    launch(1, 1, 32'h0001_F100, 1);
    wait_done("rd_wr_priority", 50);

    // Long pready stall (timeout behaviour depends on build)
    fill_beats(0, 0);
    bw[0] = 20;
    launch(0, 1, 32'h0002_F020, 0);
    wait_done("long_wait", 60);

    // Reset during ACCESS of beat 2 of 4
    fill_beats(3, 0);
    c = done_seen;
    launch(0, 1, 32'h0001_F010, 3);
    len = 0;
    while (!(done_seen == c + 1 && penable_o) && len < 200) begin
      tick();
      len++;
    end
    chk("abort_reach_access", len < 200, 1);
    rst_n = 0;
    #1;
    chk("abort_psel", psel_o, 2'b00);
    chk("abort_penable", penable_o, 0);
    chk("abort_done", trans_done_o, 0);
    chk("abort_err", trans_error_o, 0);
    chk("abort_rdata", read_data_o, 0);
    chk("abort_paddr", paddr_o, 0);
    chk("abort_pwrite", pwrite_o, 0);
    chk("abort_rden", fifo_rden_o, 0);
    exp_acc.delete();
    exp_done.delete();
    plan_q.delete();
    fifo_q.delete();
    acc_exp  = acc_seen;
    done_exp = done_seen;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", trans_done_o, 0);
    end
    rst_n = 1;
    tick();
    fill_beats(2, 20);
    launch(0, 1, 32'h0001_F200, 1);
    wait_done("after_reset", 60);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a[31:12] = 20'h0001F;
        3, 4, 5: a[31:12] = 20'h0002F;
        6:       a[31:12] = 20'h00030;
        default: a[31:12] = 20'($urandom());
      endcase
      a[11:0] = ($urandom_range(0, 1) != 0) ? 12'(4 * $urandom_range(1008, 1023))
                                             : 12'(4 * $urandom_range(0, 1023));
      len = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0:       begin wr = 0; rd = 1; end
        1:       begin wr = 1; rd = 0; end
        default: begin wr = 1; rd = 1; end
      endcase
      fill_beats(3, 25);
      stall = wr && !rd && ($urandom_range(0, 1) != 0);
      launch(wr, rd, a, len);
      if (stall) begin
        c = $urandom_range(1, 4);
        for (int k = 0; k < c; k++) tick();
        stall = 0;
        fifo_update();
      end
      wait_done("random", 400);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
